// File: rtl/gnn_job_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnn_job_ctrl : round-robin job sequencer for a two-requester GNN datapath.  |
// | Optional WAIT timeout enabled by defining GNN_CTRL_TIMEOUT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gnn_job_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [79:0]  req0_x,
  input  logic [79:0]  req1_x,
  output logic         eng_in_ready,
  output logic [79:0]  eng_x,
  input  logic [7:0]   eng_out_rdy,
  input  logic [167:0] eng_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [167:0] rsp_data,
  output logic         rsp_err
);

  if ((TIMEOUT_CYC < 4) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("gnn_job_ctrl: TIMEOUT_CYC must be within 4..255");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t         state_q;
  logic           last_q;
  logic           eng_in_ready_q;
  logic [79:0]    eng_x_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [167:0]   rsp_data_q;
  logic [7:0]     mask_q;
  logic [7:0]     mask_d;
  logic           any_req;
  logic           gnt_sel;
  logic           grant_en;
  logic           mask_done;
  logic           timeout;

  // Prefer the requester that was not granted last; gated by rst_n so no
  // handshake can complete while the block is held in reset.
  assign any_req    = req0_valid | req1_valid;
  assign gnt_sel    = last_q ? ~req0_valid : req1_valid;
  assign grant_en   = rst_n & (state_q == S_IDLE) & any_req;
  assign req0_ready = grant_en & ~gnt_sel;
  assign req1_ready = grant_en & gnt_sel;

  assign mask_d     = mask_q | eng_out_rdy;
  assign mask_done  = &mask_d;

`ifdef GNN_CTRL_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       rsp_err_q;

  assign cnt_d   = cnt_q + 8'd1;
  assign timeout = (cnt_d == 8'(TIMEOUT_CYC));
  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_q         <= 1'b1;
      eng_in_ready_q <= 1'b0;
      eng_x_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_data_q     <= '0;
      mask_q         <= '0;
`ifdef GNN_CTRL_TIMEOUT_EN
      cnt_q          <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            eng_x_q        <= gnt_sel ? req1_x : req0_x;
            rsp_id_q       <= gnt_sel;
            last_q         <= gnt_sel;
            mask_q         <= '0;
            rsp_data_q     <= '0;
            eng_in_ready_q <= 1'b1;
            state_q        <= S_LAUNCH;
`ifdef GNN_CTRL_TIMEOUT_EN
            cnt_q          <= '0;
            rsp_err_q      <= 1'b0;
`endif
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          mask_q <= mask_d;
          for (int i = 0; i < 8; i++) begin
            if (eng_out_rdy[i]) rsp_data_q[i*21 +: 21] <= eng_out[i*21 +: 21];
          end
`ifdef GNN_CTRL_TIMEOUT_EN
          cnt_q <= cnt_d;
          if (!mask_done && timeout) rsp_err_q <= 1'b1;
`endif
          // A completing mask wins over a timeout landing on the same cycle.
          if (mask_done || timeout) begin
            eng_in_ready_q <= 1'b0;
            rsp_valid_q    <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_GAP;
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_in_ready = eng_in_ready_q;
  assign eng_x        = eng_x_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_gnn_job_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gnn_job_ctrl : directed self-checking bench for gnn_job_ctrl.            |
// | Timeout expectations follow GNN_CTRL_TIMEOUT_EN.  Revision: 1.0             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gnn_job_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [79:0]  req0_x, req1_x;
  logic         eng_in_ready;
  logic [79:0]  eng_x;
  logic [7:0]   eng_out_rdy;
  logic [167:0] eng_out;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [167:0] rsp_data;

  int           checks = 0;
  int           errors = 0;
  logic [20:0]  v;
  logic [167:0] pat;

  gnn_job_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_x(req0_x), .req1_x(req1_x),
    .eng_in_ready(eng_in_ready), .eng_x(eng_x),
    .eng_out_rdy(eng_out_rdy), .eng_out(eng_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [79:0] feats(input logic [4:0] f);
    return {16{f}};
  endfunction

  function automatic logic [167:0] rep8(input logic [20:0] s);
    return {8{s}};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk80(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk168(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant in IDLE and checks who got it.
  task automatic wait_grant(input logic exp_id, input string tag);
    int n;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && (n < 20)) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk1({tag, "_grant_seen"}, (n < 20), 1'b1);
    chk1({tag, "_req0_ready"}, req0_ready, ~exp_id);
    chk1({tag, "_req1_ready"}, req1_ready, exp_id);
    chk1({tag, "_idle_eir_low"}, eng_in_ready, 1'b0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1({tag, "_gap_rsp_valid"}, rsp_valid, 1'b0);
    chk1({tag, "_gap_eir"}, eng_in_ready, 1'b0);
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req1_x = '0;
    eng_out_rdy = '0; eng_out = '0; rsp_ready = 1'b0;

    // Reset values, and no ready while held in reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    #1;
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_eir", eng_in_ready, 1'b0);
    chk80("rst_eng_x", eng_x, '0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chk168("rst_rsp_data", rsp_data, '0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single job: outputs all 100 in WAIT cycle 3
    req0_x = feats(5'd1); req0_valid = 1'b1;
    wait_grant(1'b0, "t1");
    step();
    chk1("t1_launch_req0_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    chk1("t1_launch_eir", eng_in_ready, 1'b1);
    chk80("t1_eng_x", eng_x, feats(5'd1));
    step(); step(); step();
    eng_out_rdy = 8'hFF; eng_out = rep8(21'd100);
    chk1("t1_wait_eir", eng_in_ready, 1'b1);
    chk1("t1_wait_rsp_valid", rsp_valid, 1'b0);
    step();
    eng_out_rdy = '0; eng_out = '0;
    chk1("t1_rsp_valid", rsp_valid, 1'b1);
    chk1("t1_rsp_id", rsp_id, 1'b0);
    chk168("t1_rsp_data", rsp_data, rep8(21'd100));
    chk1("t1_rsp_err", rsp_err, 1'b0);
    chk1("t1_resp_eir", eng_in_ready, 1'b0);
    handshake("t1");

    // Staggered flags on a req1 job
    req1_x = feats(5'h1F); req1_valid = 1'b1;
    wait_grant(1'b1, "t3");
    step();
    req1_valid = 1'b0;
    chk80("t3_eng_x", eng_x, feats(5'h1F));
    step(); step();
    eng_out_rdy = 8'h0F; eng_out = {{4{21'h0ABCD}}, {4{21'd5}}};
    step();
    eng_out_rdy = '0; eng_out = rep8(21'h01234);
    step();
    eng_out_rdy = 8'hF0; eng_out = {{4{21'h1FFFF9}}, {4{21'd3}}};
    chk1("t3_c4_rsp_valid", rsp_valid, 1'b0);
    step();
    eng_out_rdy = '0;
    chk1("t3_rsp_valid", rsp_valid, 1'b1);
    chk1("t3_rsp_id", rsp_id, 1'b1);
    chk168("t3_rsp_data", rsp_data, {{4{21'h1FFFF9}}, {4{21'd5}}});
    chk1("t3_rsp_err", rsp_err, 1'b0);
    handshake("t3");

    // Contention: both always valid, expect 0,1,0,1
    req0_x = feats(5'd2); req1_x = feats(5'd3);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_grant(j[0], "t2");
      step();
      chk80("t2_eng_x", eng_x, j[0] ? feats(5'd3) : feats(5'd2));
      v = 21'(11 * (j + 1));
      eng_out_rdy = 8'hFF; eng_out = rep8(v);
      step(); step();
      eng_out_rdy = '0;
      chk1("t2_rsp_valid", rsp_valid, 1'b1);
      chk1("t2_rsp_id", rsp_id, j[0]);
      chk168("t2_rsp_data", rsp_data, rep8(v));
      handshake("t2");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Timeout: only slice 0 ever flagged
    req0_x = feats(5'd4); req0_valid = 1'b1;
    wait_grant(1'b0, "t4");
    step();
    req0_valid = 1'b0;
    step();
    eng_out_rdy = 8'h01; eng_out = {{7{21'd3}}, 21'd9};
    repeat (7) step();
    chk1("t4_c8_rsp_valid", rsp_valid, 1'b0);
    chk1("t4_c8_eir", eng_in_ready, 1'b1);
    step();
`ifdef GNN_CTRL_TIMEOUT_EN
    eng_out_rdy = '0;
    chk1("t4_rsp_valid", rsp_valid, 1'b1);
    chk1("t4_rsp_err", rsp_err, 1'b1);
    chk1("t4_rsp_id", rsp_id, 1'b0);
    chk168("t4_rsp_data", rsp_data, {{7{21'd0}}, 21'd9});
    chk1("t4_resp_eir", eng_in_ready, 1'b0);
`else
    chk1("t4_stay_rsp_valid", rsp_valid, 1'b0);
    chk1("t4_stay_eir", eng_in_ready, 1'b1);
    repeat (3) step();
    chk1("t4_stay2_rsp_valid", rsp_valid, 1'b0);
    eng_out_rdy = 8'hFF;
    step();
    eng_out_rdy = '0;
    chk1("t4_rsp_valid", rsp_valid, 1'b1);
    chk1("t4_rsp_err", rsp_err, 1'b0);
    chk168("t4_rsp_data", rsp_data, {{7{21'd3}}, 21'd9});
`endif
    handshake("t4");

    // Back-pressure with req0 pending throughout
    req1_x = feats(5'd5); req1_valid = 1'b1;
    req0_x = feats(5'd6); req0_valid = 1'b1;
    wait_grant(1'b1, "t5");
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) pat[i*21 +: 21] = 21'(i * 1000 + 1);
    eng_out_rdy = 8'hFF; eng_out = pat;
    step(); step();
    eng_out_rdy = 8'hFF; eng_out = rep8(21'h155555);
    for (int k = 0; k < 5; k++) begin
      chk1("t5_hold_rsp_valid", rsp_valid, 1'b1);
      chk1("t5_hold_rsp_id", rsp_id, 1'b1);
      chk168("t5_hold_rsp_data", rsp_data, pat);
      chk1("t5_hold_rsp_err", rsp_err, 1'b0);
      chk1("t5_hold_req0_ready", req0_ready, 1'b0);
      chk1("t5_hold_eir", eng_in_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; eng_out_rdy = '0;
    chk1("t5_gap_rsp_valid", rsp_valid, 1'b0);
    chk1("t5_gap_req0_ready", req0_ready, 1'b0);
    chk1("t5_gap_eir", eng_in_ready, 1'b0);
    step();
    chk1("t5_regrant_req0_ready", req0_ready, 1'b1);

    // Reset in the middle of WAIT
    step();
    req0_valid = 1'b0;
    step();
    eng_out_rdy = 8'h01; eng_out = rep8(21'd9);
    step();
    eng_out_rdy = '0;
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_rst_eir", eng_in_ready, 1'b0);
    chk80("t6_rst_eng_x", eng_x, '0);
    chk1("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("t6_rst_rsp_id", rsp_id, 1'b0);
    chk168("t6_rst_rsp_data", rsp_data, '0);
    chk1("t6_rst_rsp_err", rsp_err, 1'b0);
    req1_valid = 1'b1;
    #1;
    chk1("t6_rst_req1_ready", req1_ready, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_grant(1'b1, "t6");
    step();
    req1_valid = 1'b0;
    chk80("t6_eng_x", eng_x, feats(5'd5));
    chk1("t6_launch_rsp_valid", rsp_valid, 1'b0);
    step();
    eng_out_rdy = 8'hFF; eng_out = rep8(21'd42);
    step();
    eng_out_rdy = '0;
    chk1("t6_rsp_valid", rsp_valid, 1'b1);
    chk1("t6_rsp_id", rsp_id, 1'b1);
    chk168("t6_rsp_data", rsp_data, rep8(21'd42));
    handshake("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gnn_job_ctrl.md
GNN_JOB_CTRL -- requirements
Module: gnn_job_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8, meaning the maximum number of WAIT cycles before a job is aborted (legal 4..255).
REQ-002 SHALL have ports: clk  in  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: req0_valid / req1_valid  in  1  each requester holds a job pending.
REQ-005 SHALL have port: req0_ready / req1_ready  out  1  job accepted this cycle.
REQ-006 SHALL have port: req0_x / req1_x  in  80  features; node n, feature f at bits [(4n+f)*5 +: 5], signed.
REQ-007 SHALL have port: eng_in_ready  out  1  start level to the GNN datapath.
REQ-008 SHALL have port: eng_x  out  80  registered feature bus to the datapath, same packing as req*_x.
REQ-009 SHALL have port: eng_out_rdy  in  8  datapath ready flags; node n, output k at bit 2n+k.
REQ-010 SHALL have port: eng_out  in  168  datapath results; node n, output k at bits [(2n+k)*21 +: 21], signed.
REQ-011 SHALL have ports: rsp_valid  out  1, and rsp_ready  in  1  response handshake.
REQ-012 SHALL have port: rsp_id  out  1  requester that owns the response.
REQ-013 SHALL have port: rsp_data  out  168  captured results, same packing as eng_out.
REQ-014 SHALL have port: rsp_err  out  1  job timed out.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP, GAP.
REQ-016 In IDLE, when any req*_valid is high, SHALL grant one requester round-robin: grant the requester that was not granted last; on the first grant after reset, grant req0.
REQ-017 SHALL assert req*_ready combinationally for exactly the granted requester in the IDLE cycle of the grant, and SHALL register that requester's req*_x into eng_x.
REQ-018 SHALL record the grant as rsp_id, clear the capture mask and data, and go to LAUNCH.
REQ-019 In LAUNCH (one cycle), SHALL drive eng_in_ready high, then go to WAIT; eng_in_ready SHALL stay high throughout WAIT.
REQ-020 In WAIT, SHALL capture each eng_out slice into rsp_data on any cycle its eng_out_rdy bit is high, and set the corresponding sticky mask bit.
REQ-021 Once the mask is all-ones, including bits set that same cycle, SHALL go to RESP with rsp_err=0.
REQ-022 SHALL increment the WAIT cycle counter every WAIT cycle.
REQ-023 If the counter reaches TIMEOUT_CYC with the mask incomplete, SHALL go to RESP with rsp_err=1; uncaptured slices SHALL read zero.
REQ-024 In RESP, SHALL drive eng_in_ready low and hold rsp_valid high with rsp_id, rsp_data and rsp_err stable until rsp_ready is high, then go to GAP.
REQ-025 GAP SHALL last exactly one cycle with eng_in_ready low, guaranteeing a fresh rising edge for the datapath, then return to IDLE.
REQ-026 req*_ready SHALL be low in every state except the grant cycle in IDLE; requests arriving outside IDLE SHALL wait and SHALL NOT be dropped.
REQ-027 With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1.
REQ-028 eng_out_rdy and eng_out SHALL be ignored outside WAIT.

Reset
REQ-029 On rst_n low, SHALL asynchronously force: state IDLE, last-grant pointer to req1 (so req0 wins first), eng_in_ready=0, eng_x=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, mask=0, counter=0.
REQ-030 Reset mid-job SHALL abandon the job with no response; req*_ready SHALL be 0 while rst_n is low.

Configuration
REQ-031 With GNN_CTRL_TIMEOUT_EN defined, SHALL implement the timeout of REQ-022/REQ-023.
REQ-032 Without GNN_CTRL_TIMEOUT_EN, SHALL omit the counter, SHALL stay in WAIT until the mask completes, and SHALL tie rsp_err to 0.

Verification
REQ-033 Bench SHALL cover a single job: req0_valid with all features=1; datapath raises all 8 eng_out_rdy bits in WAIT cycle 3 with out=100 -> rsp_valid, rsp_id=0, all slices 100, rsp_err=0.
REQ-034 Bench SHALL cover contention: req0 and req1 continuously valid for 4 jobs -> grant order 0,1,0,1, and eng_in_ready low for at least 1 cycle between jobs.
REQ-035 Bench SHALL cover staggered flags: bits 0-3 high in WAIT cycle 2 only (out=5), bits 4-7 in cycle 4 (out=-7) -> rsp_data slices 0-3=5, 4-7=-7.
REQ-036 Bench SHALL cover timeout (macro defined, TIMEOUT_CYC=8): only bit 0 ever high (out=9) -> rsp_err=1 after 8 WAIT cycles, slice0=9, others 0; without the macro, the FSM stays in WAIT.
REQ-037 Bench SHALL cover back-pressure: rsp_ready low for 5 cycles -> rsp fields stable, req*_ready low, no new grant until 1 cycle after the handshake plus GAP.
REQ-038 Bench SHALL cover reset mid-WAIT: rst_n low -> all outputs return to reset values immediately; after release, req1-only valid is granted.
